ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
- Second-generation PS/2 keyboard front end. Runs fully synchronous to the system clock: it oversamples ps2_clk/ps2_data rather than clocking logic on the keyboard clock.
- Checks each frame (start, odd parity, stop, inter-edge timeout).
- Decodes the E0 (extended), F0 (break) and E1 (pause) prefix sequences.
- Keeps a held-key bitmap for NUM_PLAYERS x KEYS_PER_PLAYER keys via a parametrised key map, so keys clear on release.
- Sits between the board PS/2 pins and the game/player control logic; the debug LEDs show the last scan code.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- TIMEOUT_US, 1000, maximum gap between ps2_clk falling edges inside a frame before the frame is aborted.
- FILTER_LEN, 4, number of consecutive identical synchronised samples needed to change a filtered line level (range 2..16).
- NUM_PLAYERS, 2, number of player key groups (range 1..4).
- KEYS_PER_PLAYER, 5, keys per player; bit order is up, left, right, down, fire (range 1..8).
- KEYMAP, see package default, NUM_PLAYERS*KEYS_PER_PLAYER entries of 9 bits {ext, code[7:0]}. Entry i maps to keys[i]. The default reproduces P1 = E0 75/E0 6B/E0 74/E0 72/29 and P2 = 1D/1C/23/1B/0D.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw keyboard clock pin (asynchronous)
- ps2_data  in  1  raw keyboard data pin (asynchronous)
- keys  out  NUM_PLAYERS*KEYS_PER_PLAYER  held-key bitmap; player p, key k is bit p*KEYS_PER_PLAYER+k
- code_valid  out  1  one-cycle pulse when a complete make/break code has been decoded
- code  out  8  final (non-prefix) byte of the decoded code; held until next code_valid
- code_ext  out  1  code was E0-prefixed; held with code
- code_break  out  1  code was F0-prefixed (release); held with code
- frame_err  out  1  one-cycle pulse on bad start, bad stop or timeout
- parity_err  out  1  one-cycle pulse on odd-parity failure
- debug_leds  out  8  last byte received correctly, including prefix bytes

Behaviour:
- Reset: all outputs 0; FSM in IDLE; prefix flags and skip counter cleared; synchronisers and filters preset to 1 (lines idle high).
- Input conditioning:
  - 2-flop synchroniser on each line, then the FILTER_LEN counter filter.
  - A falling edge is filtered ps2_clk going 1->0. Data is sampled as the filtered ps2_data in the edge cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data=0 go to DATA with bit counter 0. An edge with data=1 is ignored and raises no error.
  - DATA: shift bits in LSB first. After the 8th bit go to PARITY.
  - PARITY: latch the parity bit and go to STOP.
  - STOP: on the edge, if data=0, pulse frame_err and discard the byte. Otherwise, if the XOR of the 8 data bits and the parity bit is not 1, pulse parity_err and discard. Otherwise the byte is accepted in that cycle. Return to IDLE in all cases.
- Timeout:
  - Counter of TIMEOUT_CYCLES = CLK_HZ/1000000*TIMEOUT_US cycles, reloaded on every edge. Runs only when the FSM is not in IDLE.
  - On expiry: pulse frame_err, return to IDLE, clear the prefix flags.
  - The held-key bitmap is kept on timeout.
- Byte decoder (acts in the cycle a byte is accepted; debug_leds updated in the same cycle):
  - Skip counter nonzero: decrement it and ignore the byte.
  - E1: load skip counter with 7 (pause sequence); clear the prefix flags.
  - E0: set ext flag.
  - F0: set brk flag.
  - AA with no prefix flags set (power-on self-test passed): clear all keys. No code_valid.
  - Any other byte:
    - Pulse code_valid next cycle; code/code_ext/code_break are registered with it.
    - For each KEYMAP entry equal to {ext, byte}, set the keys bit if brk=0 and clear it if brk=1.
    - Clear both flags.
  - Latency: keys changes and code_valid asserts 1 cycle after the accepting STOP edge cycle.
- Multiple keymap entries may match one code; all of them update. Unmapped codes still pulse code_valid.
- Repeated makes (typematic) re-set an already-set bit and cause no change.
- An error in a frame never changes keys or the flags, except timeout, which clears the flags.
- When the skip counter is active, prefix handling is suspended.

Decomposition:
- Package ps2_pkg holds:
  - scan code constants: PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, PS2_BAT=AA;
  - key-index localparams (KEY_UP=0 .. KEY_FIRE=4);
  - the default 2x5 KEYMAP vector;
  - a function computing TIMEOUT_CYCLES.
- Sub-module ps2_line_filter (synchroniser plus counter filter, parameter FILTER_LEN) is instantiated twice. Frame FSM and decoder stay in the top module.

Test Plan:
- Frame 1C with correct parity -> code_valid once, code=1C, ext=0, brk=0, keys[6]=1 one cycle after the stop edge, debug_leds=1C.
- Bytes E0 75, then E0 F0 75 -> keys[0] rises after the first code, falls after the second; code_break=1 on the second; debug_leds shows E0/F0/75 as received.
- Hold 29 and 1D together, then release 29 only -> keys[4] goes 1->0; keys[5] stays 1.
- Frame 1D with parity bit flipped -> parity_err pulse; no code_valid; keys unchanged. Frame with stop=0 -> frame_err pulse.
- 4 data bits, then silence longer than TIMEOUT_US -> frame_err pulse; the next clean frame 1C decodes normally. A 1-cycle glitch on ps2_clk is rejected by the filter.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> no code_valid and keys unchanged. Then AA with keys set -> all keys 0. Assert rst_n low mid-frame -> all outputs 0 and the next frame decodes.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, default key map and timing helper for the PS/2 key tracker.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_BAT   = 8'hAA;

  localparam int unsigned KEY_UP    = 0;
  localparam int unsigned KEY_LEFT  = 1;
  localparam int unsigned KEY_RIGHT = 2;
  localparam int unsigned KEY_DOWN  = 3;
  localparam int unsigned KEY_FIRE  = 4;

  localparam int unsigned KEYMAP_W = 9;

  // Entry i = bits [i*9 +: 9] = {ext, code}; P1 arrows + fire, then P2 WASD-style keys.
  localparam logic [10*KEYMAP_W-1:0] KEYMAP_DEFAULT = {
    {1'b0, 8'h0D}, {1'b0, 8'h1B}, {1'b0, 8'h23}, {1'b0, 8'h1C}, {1'b0, 8'h1D},
    {1'b0, 8'h29}, {1'b1, 8'h72}, {1'b1, 8'h74}, {1'b1, 8'h6B}, {1'b1, 8'h75}
  };

  function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                 input int unsigned timeout_us);
    return (clk_hz / 1000000) * timeout_us;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a consecutive-sample counter filter; idles high.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  localparam int unsigned CW = $clog2(FILTER_LEN);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // Level flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt   <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_q[1] == filt) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt  <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver: oversampled frame checker, prefix decoder and held-key bitmap.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100000000,
  parameter int unsigned TIMEOUT_US      = 1000,
  parameter int unsigned FILTER_LEN      = 4,
  parameter int unsigned NUM_PLAYERS     = 2,
  parameter int unsigned KEYS_PER_PLAYER = 5,
  parameter logic [NUM_PLAYERS*KEYS_PER_PLAYER*KEYMAP_W-1:0] KEYMAP = KEYMAP_DEFAULT
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   ps2_clk,
  input  logic                                   ps2_data,
  output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0] keys,
  output logic                                   code_valid,
  output logic [7:0]                             code,
  output logic                                   code_ext,
  output logic                                   code_break,
  output logic                                   frame_err,
  output logic                                   parity_err,
  output logic [7:0]                             debug_leds
);

  localparam int unsigned NK = NUM_PLAYERS * KEYS_PER_PLAYER;
  localparam int unsigned TO = timeout_cycles(CLK_HZ, TIMEOUT_US);
  localparam int unsigned TW = $clog2(TO + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state_q, next_state;
  logic          clk_f, data_f, clk_prev_q, fall;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] timer_q;
  logic          ext_q, brk_q;
  logic [2:0]    skip_q;
  logic          byte_ok_c, frame_err_c, parity_err_c, timeout_c;
  logic [NK-1:0] keys_upd_c;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk(clk), .rst_n(rst_n), .raw(ps2_clk), .filt(clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk(clk), .rst_n(rst_n), .raw(ps2_data), .filt(data_f)
  );

  assign fall = clk_prev_q & ~clk_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= next_state;
  end

  // Frame sequencing; an edge in the same cycle as expiry wins over the timeout.
  always_comb begin
    next_state   = state_q;
    byte_ok_c    = 1'b0;
    frame_err_c  = 1'b0;
    parity_err_c = 1'b0;
    timeout_c    = 1'b0;
    if (state_q != IDLE && !fall && timer_q == '0) begin
      timeout_c  = 1'b1;
      next_state = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!data_f) next_state = DATA;
        DATA:    if (bit_cnt_q == 3'd7) next_state = PARITY;
        PARITY:  next_state = STOP;
        STOP: begin
          next_state = IDLE;
          if (!data_f)                        frame_err_c  = 1'b1;
          else if (^{shift_q, parity_q} != 1'b1) parity_err_c = 1'b1;
          else                                byte_ok_c    = 1'b1;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev_q <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      timer_q    <= '0;
    end else begin
      clk_prev_q <= clk_f;
      if (fall)                                      timer_q <= TW'(TO - 1);
      else if (state_q != IDLE && timer_q != '0)     timer_q <= timer_q - TW'(1);
      if (fall) begin
        case (state_q)
          IDLE:   bit_cnt_q <= '0;
          DATA: begin
            shift_q   <= {data_f, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
          PARITY: parity_q <= data_f;
          default: ;
        endcase
      end
    end
  end

  // Every map entry matching {ext, byte} follows the make/break state.
  always_comb begin
    keys_upd_c = keys;
    for (int unsigned i = 0; i < NK; i++) begin
      if (KEYMAP[i*KEYMAP_W +: KEYMAP_W] == {ext_q, shift_q}) keys_upd_c[i] = ~brk_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys       <= '0;
      code_valid <= 1'b0;
      code       <= '0;
      code_ext   <= 1'b0;
      code_break <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      debug_leds <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skip_q     <= '0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= frame_err_c | timeout_c;
      parity_err <= parity_err_c;
      if (timeout_c) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_ok_c) begin
        debug_leds <= shift_q;
        if (skip_q != '0) begin
          skip_q <= skip_q - 3'd1;
        end else if (shift_q == PS2_PAUSE) begin
          skip_q <= 3'd7;
          ext_q  <= 1'b0;
          brk_q  <= 1'b0;
        end else if (shift_q == PS2_EXT) begin
          ext_q <= 1'b1;
        end else if (shift_q == PS2_BRK) begin
          brk_q <= 1'b1;
        end else if (shift_q == PS2_BAT && !ext_q && !brk_q) begin
          keys <= '0;
        end else begin
          code_valid <= 1'b1;
          code       <= shift_q;
          code_ext   <= ext_q;
          code_break <= brk_q;
          keys       <= keys_upd_c;
          ext_q      <= 1'b0;
          brk_q      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench: serialises PS/2 frames and scoreboards decoded codes and key state.
module tb_ps2_key_tracker;
  import ps2_pkg::*;

  localparam int unsigned NK = 10;
  localparam int unsigned H  = 20;
  localparam int unsigned FL = 4;

  typedef struct packed {
    logic [7:0]    code;
    logic          ext;
    logic          brk;
    logic [NK-1:0] keys;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ps2_clk, ps2_data;
  logic [NK-1:0] keys;
  logic          code_valid, code_ext, code_break, frame_err, parity_err;
  logic [7:0]    code, debug_leds;

  int   tests = 0, fails = 0;
  int   fe_cnt = 0, pe_cnt = 0, cv_cnt = 0;
  int   cyc = 0, edge_cyc = 0, last_lat = -1;
  int   fe0, pe0, cv0;
  exp_t sb[$];

  ps2_key_tracker #(.CLK_HZ(10000000), .TIMEOUT_US(20), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keys(keys), .code_valid(code_valid), .code(code), .code_ext(code_ext),
    .code_break(code_break), .frame_err(frame_err), .parity_err(parity_err),
    .debug_leds(debug_leds)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer and error-pulse counters.
  always @(negedge clk) begin
    if (frame_err)  fe_cnt++;
    if (parity_err) pe_cnt++;
    if (code_valid) begin
      exp_t e;
      cv_cnt++;
      last_lat = cyc - edge_cyc;
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_code: observed %0h expected none", code);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_code", 32'(code), 32'(e.code));
        check("sb_ext",  32'(code_ext), 32'(e.ext));
        check("sb_brk",  32'(code_break), 32'(e.brk));
        check("sb_keys", 32'(keys), 32'(e.keys));
      end
    end
  end

  task automatic push(input logic [7:0] c, input logic e, input logic b, input logic [NK-1:0] k);
    exp_t x;
    x.code = c; x.ext = e; x.brk = b; x.keys = k;
    sb.push_back(x);
  endtask

  // Sends the first nbits bits (start, data, parity, stop) of an odd-parity frame.
  task automatic send_bits(input logic [7:0] b, input logic flip, input logic stop, input int nbits);
    logic [10:0] f;
    f = {stop, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) edge_cyc = cyc;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (H) @(negedge clk);
    ps2_data = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 1'b0, 1'b1, 11);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_keys", 32'(keys), 32'd0);
    check("rst_outs", 32'({code_valid, code_ext, code_break, frame_err, parity_err}), 32'd0);
    check("rst_code", 32'({code, debug_leds}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single make: latency = 2 sync + FILTER_LEN filter + 1 register.
    push(8'h1C, 1'b0, 1'b0, 10'h040);
    send(8'h1C);
    drain("drain_1c");
    check("lat_1c", 32'(last_lat), 32'(2 + FL + 1));
    check("leds_1c", 32'(debug_leds), 32'h1C);
    check("keys_1c", 32'(keys), 32'h040);

    // Extended make then extended break.
    push(8'h75, 1'b1, 1'b0, 10'h041);
    send(8'hE0);
    check("leds_e0", 32'(debug_leds), 32'hE0);
    send(8'h75);
    drain("drain_e075");
    push(8'h75, 1'b1, 1'b1, 10'h040);
    send(8'hE0);
    send(8'hF0);
    check("leds_f0", 32'(debug_leds), 32'hF0);
    send(8'h75);
    drain("drain_e0f075");
    check("leds_75", 32'(debug_leds), 32'h75);
    check("keys_up_rel", 32'(keys), 32'h040);

    // Two keys held, release only one.
    push(8'h29, 1'b0, 1'b0, 10'h050);
    send(8'h29);
    push(8'h1D, 1'b0, 1'b0, 10'h070);
    send(8'h1D);
    push(8'h29, 1'b0, 1'b1, 10'h060);
    send(8'hF0);
    send(8'h29);
    drain("drain_hold");
    check("keys_hold", 32'(keys), 32'h060);

    // Parity and stop-bit errors.
    fe0 = fe_cnt; pe0 = pe_cnt; cv0 = cv_cnt;
    send_bits(8'h1D, 1'b1, 1'b1, 11);
    check("pe_pulse", 32'(pe_cnt - pe0), 32'd1);
    check("pe_leds", 32'(debug_leds), 32'h29);
    send_bits(8'h1C, 1'b0, 1'b0, 11);
    check("fe_stop", 32'(fe_cnt - fe0), 32'd1);
    check("err_no_code", 32'(cv_cnt - cv0), 32'd0);
    check("err_keys", 32'(keys), 32'h060);

    // Timeout mid-frame clears a pending E0; next frames decode plainly.
    fe0 = fe_cnt;
    send(8'hE0);
    send_bits(8'h00, 1'b0, 1'b1, 5);
    repeat (400) @(negedge clk);
    check("fe_timeout", 32'(fe_cnt - fe0), 32'd1);
    check("to_keys", 32'(keys), 32'h060);
    push(8'h75, 1'b0, 1'b0, 10'h060);
    send(8'h75);
    push(8'h1C, 1'b0, 1'b0, 10'h060);
    send(8'h1C);
    drain("drain_after_to");

    // One-cycle clock glitch with data low must not start a frame.
    fe0 = fe_cnt; cv0 = cv_cnt;
    @(negedge clk); ps2_data = 1'b0;
    repeat (10) @(negedge clk); ps2_clk = 1'b0;
    @(negedge clk); ps2_clk = 1'b1;
    repeat (400) @(negedge clk);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);

    // Pause sequence is swallowed entirely.
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check("pause_no_code", 32'(cv_cnt - cv0), 32'd0);
    check("pause_keys", 32'(keys), 32'h060);
    check("pause_leds", 32'(debug_leds), 32'h77);

    // Self-test pass clears all held keys.
    send(8'hAA);
    check("bat_keys", 32'(keys), 32'd0);
    check("bat_no_code", 32'(cv_cnt - cv0), 32'd0);

    // Reset mid-frame, then a clean frame.
    push(8'h1C, 1'b0, 1'b0, 10'h040);
    send(8'h1C);
    drain("drain_pre_rst");
    send_bits(8'h55, 1'b0, 1'b1, 4);
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_keys", 32'(keys), 32'd0);
    check("mid_rst_outs", 32'({code_valid, code_ext, code_break, frame_err, parity_err}), 32'd0);
    check("mid_rst_code", 32'({code, debug_leds}), 32'd0);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    push(8'h1B, 1'b0, 1'b0, 10'h100);
    send(8'h1B);
    drain("drain_post_rst");
    check("post_rst_code", 32'(code), 32'h1B);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
